// File: rtl/smt_thread_sched.sv
// smt_thread_sched: per-cycle hardware-thread selector for the shared SMT
// frontend slot. Fine mode rotates round-robin over eligible threads; coarse
// mode stays on one thread until it stalls or its grant quantum expires.
// Also keeps a wrapping per-thread count of accepted grants.
module smt_thread_sched #(
    parameter int unsigned NUM_THREADS     = 2,
    parameter int unsigned NUM_THREADS_LOG = $clog2(NUM_THREADS),
    parameter int unsigned QUANTUM_W       = 8,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         mode_i,
    input  logic [QUANTUM_W-1:0]         quantum_i,
    input  logic [NUM_THREADS-1:0]       thread_en_i,
    input  logic [NUM_THREADS-1:0]       thread_stall_i,
    input  logic                         ready_i,
    output logic                         valid_o,
    output logic [NUM_THREADS_LOG-1:0]   tid_o,
    output logic [NUM_THREADS-1:0]       tid_onehot_o,
    output logic                         switch_o,
    input  logic                         clr_cnt_i,
    output logic [NUM_THREADS*CNT_W-1:0] grant_cnt_o
);

    logic [NUM_THREADS_LOG-1:0] r_tid;
    logic [QUANTUM_W-1:0]       r_qcnt;
    logic                       r_switch;
    logic [CNT_W-1:0]           r_cnt [NUM_THREADS];

    logic [NUM_THREADS-1:0]     w_elig;
    logic                       w_valid;
    logic                       w_hs;
    logic                       w_expire;
    logic                       w_found;
    logic [NUM_THREADS_LOG-1:0] w_idx;
    logic [NUM_THREADS_LOG-1:0] w_nxt;
    logic [NUM_THREADS_LOG-1:0] w_tid_d;
    logic [QUANTUM_W-1:0]       w_qcnt_d;

    assign w_elig   = thread_en_i & ~thread_stall_i;
    assign w_valid  = w_elig[r_tid];
    assign w_hs     = w_valid & ready_i;
    // A zero quantum disables forced switching; a quantum lowered below the
    // running count only matches again after the counter wraps.
    assign w_expire = (quantum_i != {QUANTUM_W{1'b0}}) &&
                      (r_qcnt == (quantum_i - QUANTUM_W'(1'b1)));

    assign valid_o  = w_valid;
    assign tid_o    = r_tid;
    assign switch_o = r_switch;

    // Rotating search for the next eligible thread after r_tid; r_tid itself is probed last.
    always_comb begin
        w_nxt   = r_tid;
        w_idx   = r_tid;
        w_found = 1'b0;
        for (int k = 1; k <= int'(NUM_THREADS); k++) begin
            w_idx = NUM_THREADS_LOG'((int'(r_tid) + k) % int'(NUM_THREADS));
            if (!w_found && w_elig[w_idx]) begin
                w_nxt   = w_idx;
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state selection for the thread ID and the coarse-mode quantum counter.
    always_comb begin
        w_tid_d  = r_tid;
        w_qcnt_d = r_qcnt;
        if (!mode_i) begin
            // Fine mode keeps the quantum counter at zero, which also clears
            // it on the edge where coarse mode is left.
            w_qcnt_d = {QUANTUM_W{1'b0}};
            if (w_hs || !w_valid) begin
                w_tid_d = w_nxt;
            end else begin
                w_tid_d = r_tid;
            end
        end else begin
            if (!w_valid) begin
                w_tid_d  = w_nxt;
                w_qcnt_d = {QUANTUM_W{1'b0}};
            end else if (w_hs && w_expire) begin
                // When the current thread is the only eligible one, w_nxt
                // equals r_tid, so only the counter restarts.
                w_tid_d  = w_nxt;
                w_qcnt_d = {QUANTUM_W{1'b0}};
            end else if (w_hs) begin
                w_qcnt_d = r_qcnt + QUANTUM_W'(1'b1);
            end else begin
                w_qcnt_d = r_qcnt;
            end
        end
    end

    // Selector state and the one-cycle switch indication.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tid    <= {NUM_THREADS_LOG{1'b0}};
            r_qcnt   <= {QUANTUM_W{1'b0}};
            r_switch <= 1'b0;
        end else begin
            r_tid    <= w_tid_d;
            r_qcnt   <= w_qcnt_d;
            r_switch <= (w_tid_d != r_tid);
        end
    end

    // Per-thread grant counters; clear wins over the increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else if (clr_cnt_i) begin
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else if (w_hs) begin
            r_cnt[r_tid] <= r_cnt[r_tid] + CNT_W'(1'b1);
        end
    end

    // One-hot form of the selected thread ID.
    always_comb begin
        tid_onehot_o        = {NUM_THREADS{1'b0}};
        tid_onehot_o[r_tid] = 1'b1;
    end

    for (genvar g = 0; g < int'(NUM_THREADS); g++) begin : g_cnt_out
        assign grant_cnt_o[g*CNT_W +: CNT_W] = r_cnt[g];
    end

endmodule

// File: tb/tb_smt_thread_sched.sv
// Directed bench for smt_thread_sched with 4 threads and 8-bit counters:
// a per-cycle vector table followed by hand-written wrap and reset sequences.
module tb_smt_thread_sched;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [7:0]  quantum;
    logic [3:0]  en;
    logic [3:0]  stall;
    logic        ready;
    logic        clr;
    logic        valid;
    logic [1:0]  tid;
    logic [3:0]  onehot;
    logic        sw;
    logic [31:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        mode;
        logic [7:0]  quantum;
        logic [3:0]  en;
        logic [3:0]  stall;
        logic        ready;
        logic        clr;
        logic        ev;
        logic [1:0]  etid;
        logic        esw;
        logic        chk;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    smt_thread_sched #(
        .NUM_THREADS(4),
        .QUANTUM_W  (8),
        .CNT_W      (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mode_i        (mode),
        .quantum_i     (quantum),
        .thread_en_i   (en),
        .thread_stall_i(stall),
        .ready_i       (ready),
        .valid_o       (valid),
        .tid_o         (tid),
        .tid_onehot_o  (onehot),
        .switch_o      (sw),
        .clr_cnt_i     (clr),
        .grant_cnt_o   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic m, input logic [7:0] q, input logic [3:0] e, input logic [3:0] s,
                       input logic r, input logic c, input logic ev, input logic [1:0] et,
                       input logic es, input logic ck, input logic [31:0] ec);
        vec_t v;
        v.mode = m; v.quantum = q; v.en = e; v.stall = s; v.ready = r; v.clr = c;
        v.ev = ev; v.etid = et; v.esw = es; v.chk = ck; v.ecnt = ec;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] exp_oh;

        // Fine round-robin, all eligible: 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) begin
            add(1'b0, 8'd0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'(i), (i != 0), (i == 0), 32'h0);
        end
        // Stall skip on thread 1: 0,2,3,0,2
        add(1'b0, 8'd0, 4'hF, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 32'h02020202);
        add(1'b0, 8'd0, 4'hF, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 32'h0);
        add(1'b0, 8'd0, 4'hF, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 32'h0);
        add(1'b0, 8'd0, 4'hF, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0);
        add(1'b0, 8'd0, 4'hF, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 32'h0);
        // Backpressure for 5 cycles: thread and counters hold
        add(1'b0, 8'd0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 32'h03040204);
        for (int i = 0; i < 4; i++) begin
            add(1'b0, 8'd0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, (i == 3), 32'h03040204);
        end
        // Coarse, quantum 3: 3,3,3,0,0,0,1,1,1,2
        add(1'b1, 8'd3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 32'h0);
        add(1'b1, 8'd3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 32'h0);
        add(1'b1, 8'd3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 32'h0);
        add(1'b1, 8'd3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0);
        add(1'b1, 8'd3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0);
        add(1'b1, 8'd3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0);
        add(1'b1, 8'd3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 32'h0);
        add(1'b1, 8'd3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 32'h0);
        add(1'b1, 8'd3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 32'h0);
        add(1'b1, 8'd3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 32'h0);
        // Coarse stall of thread 2 at its second grant: valid low, then thread 3
        add(1'b1, 8'd3, 4'hF, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0);
        add(1'b1, 8'd3, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 32'h06050507);
        // Only thread 2 enabled, quantum 2: stays on thread 2 through expiries
        add(1'b1, 8'd2, 4'b0100, 4'h0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 32'h0);
        add(1'b1, 8'd2, 4'b0100, 4'h0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            add(1'b1, 8'd2, 4'b0100, 4'h0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0);
        end
        // Clear together with a handshake, then counters read zero
        add(1'b1, 8'd2, 4'b0100, 4'h0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 32'h070a0507);
        add(1'b1, 8'd2, 4'b0100, 4'h0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 32'h0);

        // Reset state
        rst_n = 1'b0; mode = 1'b0; quantum = 8'd0; en = 4'h0; stall = 4'h0;
        ready = 1'b0; clr = 1'b0;
        #3;
        check("reset_tid", 32'(tid), 32'h0);
        check("reset_switch", 32'(sw), 32'h0);
        check("reset_cnt", cnt, 32'h0);
        check("reset_valid_dis", 32'(valid), 32'h0);
        check("reset_onehot", 32'(onehot), 32'h1);
        en = 4'hF;
        #1;
        check("reset_valid_en", 32'(valid), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven per-cycle vectors
        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            mode = vecs[r].mode; quantum = vecs[r].quantum; en = vecs[r].en;
            stall = vecs[r].stall; ready = vecs[r].ready; clr = vecs[r].clr;
            #1;
            exp_oh = 4'b0001 << vecs[r].etid;
            check($sformatf("row%0d_valid", r), 32'(valid), 32'(vecs[r].ev));
            check($sformatf("row%0d_tid", r), 32'(tid), 32'(vecs[r].etid));
            check($sformatf("row%0d_switch", r), 32'(sw), 32'(vecs[r].esw));
            check($sformatf("row%0d_onehot", r), 32'(onehot), 32'(exp_oh));
            if (vecs[r].chk) begin
                check($sformatf("row%0d_cnt", r), cnt, vecs[r].ecnt);
            end
        end

        // Counter wrap: clear, 255 grants to thread 0, then one more
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            mode = 1'b0; en = 4'b0001; stall = 4'h0; ready = 1'b1;
            clr = (n == 0);
        end
        @(negedge clk);
        #1;
        check("wrap_max", cnt, 32'h000000FF);
        @(negedge clk);
        #1;
        check("wrap_zero", cnt, 32'h0);

        // Asynchronous reset in the middle of a coarse quantum
        @(negedge clk);
        mode = 1'b1; quantum = 8'd3; en = 4'hF; ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("midq_tid", 32'(tid), 32'h1);
        check("midq_cnt", cnt, 32'h00000104);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_tid", 32'(tid), 32'h0);
        check("async_switch", 32'(sw), 32'h0);
        check("async_cnt", cnt, 32'h0);
        check("async_valid", 32'(valid), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_tid", 32'(tid), 32'h0);
        check("post_rst_switch", 32'(sw), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
